// File: rtl/cache_pkg.sv
// Shared types and width helpers for the L1 cache miss path and its
// backing-memory responder.
package cache_pkg;

  // Responder control states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_BURST = 3'd2,
    WR_BURST = 3'd3,
    WR_WAIT  = 3'd4
  } state_t;

  // Beat counter width: max(1, clog2(words_per_line)).
  function automatic int unsigned beat_width(input int unsigned wpl);
    return (wpl > 1) ? $clog2(wpl) : 1;
  endfunction

  // Latency counter width: max(1, clog2(latency + 1)).
  function automatic int unsigned lat_width(input int unsigned lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

endpackage

// File: rtl/cache_mem_responder_mem_array.sv
// mem_array: single-port word array, synchronous write, synchronous
// registered read. Contents have no reset; only the read register clears.
// Ports: clk, rst, i_we/i_wdata (write), i_re (read enable),
//        i_addr (shared word index), o_rdata (registered read data).
module mem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned IDX_W      = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [IDX_W-1:0]      i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage write; deliberately not reset so data survives rst.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // Read register doubles as the responder's rdata output register.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: next-level memory behind L1Cache. Serves line refill
// reads and line writebacks as WORDS_PER_LINE-beat bursts after a fixed
// LATENCY, one request at a time.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_write/req_addr
// (request); wdata_valid/wdata/wdata_ready (writeback beats);
// rdata_valid/rdata/rdata_last (refill beats, no backpressure);
// wr_done (writeback complete pulse).
module cache_mem_responder
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned LATENCY        = 3,
  parameter int unsigned MEM_WORDS      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  wdata_valid,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_ready,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic                  wr_done
);

  localparam int unsigned BEAT_W = beat_width(WORDS_PER_LINE);
  localparam int unsigned LAT_W  = lat_width(LATENCY);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY);
  localparam logic [IDX_W-1:0]  LINE_MASK = ~IDX_W'(WORDS_PER_LINE - 1);

  state_t             r_state, w_next_state;
  logic [LAT_W-1:0]   r_cnt, w_cnt_next;
  logic [BEAT_W-1:0]  r_beat, w_beat_next, w_beat_inc, w_issue_beat;
  logic [IDX_W-1:0]   r_base, w_base_next, w_req_base, w_mem_addr;
  logic               r_rdata_valid, r_rdata_last, r_wr_done;
  logic               w_rd_issue, w_mem_we, w_wr_done_next;
  logic               w_unused_addr;

  // Word index wraps modulo MEM_WORDS; byte offset and high bits are dropped.
  assign w_req_base    = req_addr[IDX_W+1:2] & LINE_MASK;
  assign w_unused_addr = ^req_addr;
  assign w_beat_inc    = r_beat + BEAT_W'(1);

  // Next-state and datapath decode. Reads are issued one cycle ahead of the
  // beat becoming visible, so RD_BURST spans exactly the visible beats.
  always_comb begin
    w_next_state   = r_state;
    w_cnt_next     = r_cnt;
    w_beat_next    = r_beat;
    w_base_next    = r_base;
    w_rd_issue     = 1'b0;
    w_issue_beat   = '0;
    w_mem_we       = 1'b0;
    w_wr_done_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_next_state = req_write ? WR_BURST : RD_WAIT;
          w_base_next  = w_req_base;
          w_beat_next  = '0;
          w_cnt_next   = LAT_LOAD;
        end
      end
      RD_WAIT: begin
        if (r_cnt == '0) begin
          w_rd_issue   = 1'b1;
          w_next_state = RD_BURST;
        end else begin
          w_cnt_next = r_cnt - LAT_W'(1);
        end
      end
      RD_BURST: begin
        if (r_beat == LAST_BEAT) begin
          w_next_state = IDLE;
        end else begin
          w_rd_issue   = 1'b1;
          w_issue_beat = w_beat_inc;
          w_beat_next  = w_beat_inc;
        end
      end
      WR_BURST: begin
        if (wdata_valid) begin
          w_mem_we    = 1'b1;
          w_beat_next = w_beat_inc;
          if (r_beat == LAST_BEAT) begin
            w_next_state   = WR_WAIT;
            w_cnt_next     = LAT_LOAD;
            w_wr_done_next = (LATENCY == 0);
          end
        end
      end
      WR_WAIT: begin
        // wr_done is registered, so it is launched one count before expiry.
        w_wr_done_next = (r_cnt == LAT_W'(1));
        if (r_cnt == '0) w_next_state = IDLE;
        else             w_cnt_next   = r_cnt - LAT_W'(1);
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_mem_addr = r_base | IDX_W'(w_mem_we ? r_beat : w_issue_beat);

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_beat        <= '0;
      r_base        <= '0;
      r_rdata_valid <= 1'b0;
      r_rdata_last  <= 1'b0;
      r_wr_done     <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_cnt_next;
      r_beat        <= w_beat_next;
      r_base        <= w_base_next;
      r_rdata_valid <= w_rd_issue;
      r_rdata_last  <= w_rd_issue && (w_issue_beat == LAST_BEAT);
      r_wr_done     <= w_wr_done_next;
    end
  end

  mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_mem_we),
    .i_re    (w_rd_issue),
    .i_addr  (w_mem_addr),
    .i_wdata (wdata),
    .o_rdata (rdata)
  );

  assign req_ready   = (r_state == IDLE);
  assign wdata_ready = (r_state == WR_BURST);
  assign rdata_valid = r_rdata_valid;
  assign rdata_last  = r_rdata_last;
  assign wr_done     = r_wr_done;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: two instances (LATENCY=3 and LATENCY=0 with
// a small wrapping array) driven with directed and random line traffic and
// compared against a line-level memory model.
module tb_cache_mem_responder;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned WPL  = 4;
  localparam int unsigned LAT0 = 3;
  localparam int unsigned LAT1 = 0;
  localparam int unsigned MW0  = 1024;
  localparam int unsigned MW1  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid   [2];
  logic          req_ready   [2];
  logic          req_write   [2];
  logic [AW-1:0] req_addr    [2];
  logic          wdata_valid [2];
  logic [DW-1:0] wdata       [2];
  logic          wdata_ready [2];
  logic          rdata_valid [2];
  logic [DW-1:0] rdata       [2];
  logic          rdata_last  [2];
  logic          wr_done     [2];

  logic [DW-1:0] mdl   [2][MW0];
  bit            wflag [2][MW0];
  logic [AW-1:0] hist  [2][8];
  int            hist_n [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL),
    .LATENCY(LAT0), .MEM_WORDS(MW0)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]),
    .wdata_valid(wdata_valid[0]), .wdata(wdata[0]), .wdata_ready(wdata_ready[0]),
    .rdata_valid(rdata_valid[0]), .rdata(rdata[0]), .rdata_last(rdata_last[0]),
    .wr_done(wr_done[0])
  );

  cache_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL),
    .LATENCY(LAT1), .MEM_WORDS(MW1)
  ) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]),
    .wdata_valid(wdata_valid[1]), .wdata(wdata[1]), .wdata_ready(wdata_ready[1]),
    .rdata_valid(rdata_valid[1]), .rdata(rdata[1]), .rdata_last(rdata_last[1]),
    .wr_done(wr_done[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? int'(LAT0) : int'(LAT1);
  endfunction

  function automatic int mw_of(input int d);
    return (d == 0) ? int'(MW0) : int'(MW1);
  endfunction

  // Word index modulo depth, rounded down to the start of the line.
  function automatic int line_base(input int d, input logic [AW-1:0] addr);
    int unsigned idx;
    idx = int'((addr >> 2) % 32'(mw_of(d)));
    return int'(idx - (idx % WPL));
  endfunction

  task automatic quiet(input int d);
    chk("idle_req_ready",   32'(req_ready[d]),   32'd1);
    chk("idle_wdata_ready", 32'(wdata_ready[d]), 32'd0);
    chk("idle_rdata_valid", 32'(rdata_valid[d]), 32'd0);
    chk("idle_rdata_last",  32'(rdata_last[d]),  32'd0);
    chk("idle_wr_done",     32'(wr_done[d]),     32'd0);
  endtask

  // pat_len == 0 gives random wdata_valid gaps; otherwise pat bits are used
  // per cycle (LSB first), then wdata_valid stays high.
  task automatic do_write(input int d, input logic [AW-1:0] addr,
                          input logic [DW-1:0] w [WPL],
                          input logic [15:0] pat, input int pat_len);
    int   base;
    int   beats;
    int   cyc;
    logic v;
    base = line_base(d, addr);
    chk("wr_req_ready", 32'(req_ready[d]), 32'd1);
    req_valid[d]   = 1'b1;
    req_write[d]   = 1'b1;
    req_addr[d]    = addr;
    wdata_valid[d] = 1'($urandom);
    wdata[d]       = $urandom;
    tick();
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom);
    req_addr[d]  = $urandom;
    beats = 0;
    cyc   = 0;
    while (beats < int'(WPL)) begin
      if (cyc >= 200) begin
        chk("wr_beat_budget", 32'(beats), 32'(WPL));
        wdata_valid[d] = 1'b0;
        return;
      end
      if (pat_len != 0) v = (cyc < pat_len) ? pat[cyc] : 1'b1;
      else              v = ($urandom_range(0, 2) != 0);
      chk("wdata_ready", 32'(wdata_ready[d]), 32'd1);
      chk("wr_done_early", 32'(wr_done[d]), 32'd0);
      chk("wr_req_busy", 32'(req_ready[d]), 32'd0);
      wdata_valid[d] = v;
      wdata[d]       = v ? w[beats] : $urandom;
      tick();
      if (v) begin
        mdl[d][base + beats]   = w[beats];
        wflag[d][base + beats] = 1'b1;
        beats++;
      end
      cyc++;
    end
    // Beats offered after the burst must be ignored.
    wdata_valid[d] = 1'($urandom);
    wdata[d]       = $urandom;
    for (int i = 0; i < lat_of(d); i++) begin
      chk("wr_done_wait", 32'(wr_done[d]), 32'd0);
      chk("wr_wait_wready", 32'(wdata_ready[d]), 32'd0);
      chk("wr_wait_busy", 32'(req_ready[d]), 32'd0);
      tick();
    end
    chk("wr_done_pulse", 32'(wr_done[d]), 32'd1);
    chk("wr_done_busy", 32'(req_ready[d]), 32'd0);
    wdata_valid[d] = 1'b0;
    tick();
    chk("wr_done_clear", 32'(wr_done[d]), 32'd0);
    chk("wr_end_ready", 32'(req_ready[d]), 32'd1);
  endtask

  // abort_at >= 0 asserts rst during that beat. hold keeps a second read
  // (addr2) pending so it is accepted right after the burst.
  task automatic do_read(input int d, input logic [AW-1:0] addr, input int abort_at,
                         input bit hold, input logic [AW-1:0] addr2);
    int base;
    base = line_base(d, addr);
    chk("rd_req_ready", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_write[d] = 1'b0;
    req_addr[d]  = addr;
    tick();
    if (hold) begin
      req_addr[d] = addr2;
    end else begin
      req_valid[d] = 1'b0;
      req_write[d] = 1'($urandom);
      req_addr[d]  = $urandom;
    end
    for (int i = 0; i < lat_of(d) + 1; i++) begin
      chk("rd_wait_valid", 32'(rdata_valid[d]), 32'd0);
      chk("rd_wait_busy", 32'(req_ready[d]), 32'd0);
      tick();
    end
    for (int k = 0; k < int'(WPL); k++) begin
      chk("rd_valid", 32'(rdata_valid[d]), 32'd1);
      chk("rd_last", 32'(rdata_last[d]), 32'(k == int'(WPL) - 1));
      chk("rd_busy", 32'(req_ready[d]), 32'd0);
      if (wflag[d][base + k]) chk("rd_data", rdata[d], mdl[d][base + k]);
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", 32'(rdata_valid[d]), 32'd0);
        chk("abort_ready", 32'(req_ready[d]), 32'd1);
        tick();
        chk("abort_no_beat", 32'(rdata_valid[d]), 32'd0);
        return;
      end
      tick();
    end
    chk("rd_end_valid", 32'(rdata_valid[d]), 32'd0);
    chk("rd_end_last", 32'(rdata_last[d]), 32'd0);
    chk("rd_end_ready", 32'(req_ready[d]), 32'd1);
  endtask

  // Same line, different unused high bits and byte/word offset.
  function automatic logic [AW-1:0] alias_addr(input int d, input logic [AW-1:0] a);
    logic [AW-1:0] mask;
    mask = 32'(mw_of(d) * 4 - 1);
    return (32'($urandom) & ~mask) | (a & mask & ~32'hF) | (32'($urandom) & 32'hF);
  endfunction

  task automatic random_ops(input int d, input int n);
    logic [DW-1:0] w [WPL];
    logic [AW-1:0] a;
    int hn;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        quiet(d);
        tick();
      end
      if (hist_n[d] == 0 || $urandom_range(0, 1) == 0) begin
        a = $urandom;
        for (int k = 0; k < int'(WPL); k++) w[k] = $urandom;
        do_write(d, a, w, 16'h0, 0);
        hist[d][hist_n[d] % 8] = a;
        hist_n[d]++;
      end else begin
        hn = (hist_n[d] < 8) ? hist_n[d] : 8;
        a  = alias_addr(d, hist[d][$urandom_range(0, hn - 1)]);
        do_read(d, a, -1, 1'b0, '0);
      end
    end
  endtask

  initial begin
    logic [DW-1:0] w [WPL];
    for (int d = 0; d < 2; d++) begin
      req_valid[d]   = 1'b0;
      req_write[d]   = 1'b0;
      req_addr[d]    = '0;
      wdata_valid[d] = 1'b0;
      wdata[d]       = '0;
      hist_n[d]      = 0;
      for (int i = 0; i < int'(MW0); i++) wflag[d][i] = 1'b0;
    end

    // Reset values.
    rst = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      quiet(d);
      chk("rst_rdata", rdata[d], 32'd0);
    end
    rst = 1'b0;
    repeat (4) begin
      tick();
      quiet(0);
      quiet(1);
    end

    // Writeback then refill of line 0x10, then unaligned alias 0x1C.
    w = '{32'hDEADBEEF, 32'h1, 32'h2, 32'h3};
    do_write(0, 32'h10, w, 16'hFFFF, 4);
    do_read(0, 32'h10, -1, 1'b0, '0);
    do_read(0, 32'h1C, -1, 1'b0, '0);

    // Stalled writeback: valid pattern 1,0,0,1,1,0,1.
    w = '{32'hA5A50000, 32'hA5A50001, 32'hA5A50002, 32'hA5A50003};
    do_write(0, 32'h208, w, 16'b1011001, 7);
    do_read(0, 32'h200, -1, 1'b0, '0);

    // Reset during read beat 2; contents must survive.
    do_read(0, 32'h10, 2, 1'b0, '0);
    do_read(0, 32'h14, -1, 1'b0, '0);

    random_ops(0, 25);

    // LATENCY=0 instance: line at MEM_WORDS-4, read through a wrapped address
    // with a second read held pending throughout.
    w = '{32'h11110000, 32'h22220000, 32'h33330000, 32'h44440000};
    do_write(1, 32'h10, w, 16'hFFFF, 4);
    w = '{32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
    do_write(1, 32'(int'(MW1 - 4) * 4), w, 16'hFFFF, 4);
    do_read(1, 32'(int'(MW1 * 4) + int'(MW1 - 4) * 4 + 8), -1, 1'b1, 32'h18);
    do_read(1, 32'h18, -1, 1'b0, '0);

    random_ops(1, 25);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
